// File: rtl/lifo_pkg.sv
// Shared defaults and helpers for the LIFO stack.
// LIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs to the lifo top.
package lifo_pkg;

  localparam int LIFO_WIDTH = 8;
  localparam int LIFO_DEPTH = 8;

  // Pointer must reach DEPTH itself, hence one bit beyond the address width.
  function automatic int lifo_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lifo_if.sv
// Bundle of the LIFO request/status signals, shared by the stack and its driver.
// LIFO_ERR_FLAGS_EN adds the sticky overflow/underflow status lines.
interface lifo_if #(
  parameter int WIDTH = 8
);
  logic             we;
  logic             re;
  logic [WIDTH-1:0] data_in;
  logic             empty;
  logic             full;
  logic [WIDTH-1:0] data_out;
`ifdef LIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

`ifdef LIFO_ERR_FLAGS_EN
  modport master (output we, re, data_in, input empty, full, data_out, overflow, underflow);
  modport slave  (input we, re, data_in, output empty, full, data_out, overflow, underflow);
`else
  modport master (output we, re, data_in, input empty, full, data_out);
  modport slave  (input we, re, data_in, output empty, full, data_out);
`endif
endinterface

// File: rtl/lifo_mem.sv
// LIFO storage array: synchronous write port, combinational read port.
module lifo_mem
  import lifo_pkg::*;
#(
  parameter int  WIDTH = LIFO_WIDTH,
  parameter int  DEPTH = LIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/lifo.sv
// LIFO stack top: pointer, status and registered read-data control around lifo_mem.
// Define LIFO_ERR_FLAGS_EN to add sticky overflow/underflow output ports.
module lifo
  import lifo_pkg::*;
#(
  parameter int WIDTH = LIFO_WIDTH,
  parameter int DEPTH = LIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] data_in,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] data_out
`ifdef LIFO_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int             AW      = $clog2(DEPTH);
  localparam int             PW      = lifo_ptr_width(DEPTH);
  localparam logic [PW-1:0]  DEPTH_V = PW'(DEPTH);

  logic [PW-1:0]    sp_r;
  logic [WIDTH-1:0] data_out_r;
  logic [WIDTH-1:0] rd_data_s;
  logic [AW-1:0]    rd_addr_s;
  logic [AW-1:0]    wr_addr_s;
  logic             wr_en_s;
  logic             do_read_s;
  logic             do_push_s;
  logic             do_pop_only_s;
  logic             do_swap_s;

  assign empty    = (sp_r == {PW{1'b0}});
  assign full     = (sp_r == DEPTH_V);
  assign data_out = data_out_r;

  // Classify the request; a swap replaces the top entry and is allowed even when full.
  always_comb begin
    do_read_s     = 1'b0;
    do_push_s     = 1'b0;
    do_pop_only_s = 1'b0;
    do_swap_s     = 1'b0;
    if (re && !empty) begin
      do_read_s     = 1'b1;
      do_swap_s     = we;
      do_pop_only_s = !we;
    end else if (we && !full) begin
      do_push_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
    end
  end

  // Memory addressing: reads always see the top entry, writes go above it or over it.
  always_comb begin
    rd_addr_s = sp_r[AW-1:0] - 1'b1;
    wr_en_s   = do_push_s | do_swap_s;
    if (do_swap_s) begin
      wr_addr_s = rd_addr_s;
    end else begin
      wr_addr_s = sp_r[AW-1:0];
    end
  end

  lifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (data_in),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Stack pointer and registered read data; reset wins over any request.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sp_r       <= {PW{1'b0}};
      data_out_r <= {WIDTH{1'b0}};
    end else begin
      if (do_push_s) begin
        sp_r <= sp_r + 1'b1;
      end else if (do_pop_only_s) begin
        sp_r <= sp_r - 1'b1;
      end else begin
        sp_r <= sp_r;
      end
      if (do_read_s) begin
        data_out_r <= rd_data_s;
      end else begin
        data_out_r <= data_out_r;
      end
    end
  end

`ifdef LIFO_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  assign overflow  = overflow_r;
  assign underflow = underflow_r;

  // Sticky error flags; a write+read while full is a swap, not an overflow.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r  | (we && !re && full);
      underflow_r <= underflow_r | (re && !we && empty);
    end
  end
`endif

endmodule

// File: tb/tb_lifo.sv
// Directed self-checking bench for lifo; honours LIFO_ERR_FLAGS_EN when defined.
module tb_lifo;

  logic clk;
  logic rstn;
  int   n_total;
  int   n_pass;

  lifo_if #(.WIDTH(8)) bus ();

  lifo #(
    .WIDTH (8),
    .DEPTH (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .we        (bus.we),
    .re        (bus.re),
    .data_in   (bus.data_in),
    .empty     (bus.empty),
    .full      (bus.full),
    .data_out  (bus.data_out)
`ifdef LIFO_ERR_FLAGS_EN
    ,
    .overflow  (bus.overflow),
    .underflow (bus.underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given request; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    bus.we      = w;
    bus.re      = r;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.we      = 1'b0;
    bus.re      = 1'b0;
    bus.data_in = 8'd0;
  endtask

  logic [7:0] push_vals [8];
  logic [7:0] pop_vals  [10];

  initial begin
    n_total     = 0;
    n_pass      = 0;
    push_vals   = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd2, 8'd6, 8'd5};
    pop_vals    = '{8'd5, 8'd6, 8'd2, 8'd5, 8'd1, 8'd4, 8'd1, 8'd3, 8'd3, 8'd3};
    rstn        = 1'b0;
    bus.we      = 1'b0;
    bus.re      = 1'b0;
    bus.data_in = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc(1'b0, 1'b0, 8'd0);
    check_eq("rst_empty", 32'(bus.empty), 32'd1);
    check_eq("rst_full", 32'(bus.full), 32'd0);
    check_eq("rst_dout", 32'(bus.data_out), 32'd0);

    // Fill to the top, then two pushes that must be dropped.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, push_vals[i]);
      check_eq($sformatf("fill_full_%0d", i), 32'(bus.full), (i == 7) ? 32'd1 : 32'd0);
      check_eq($sformatf("fill_empty_%0d", i), 32'(bus.empty), 32'd0);
    end
    cyc(1'b1, 1'b0, 8'd7);
    cyc(1'b1, 1'b0, 8'd0);
    check_eq("ovf_full", 32'(bus.full), 32'd1);
    check_eq("ovf_dout", 32'(bus.data_out), 32'd0);
`ifdef LIFO_ERR_FLAGS_EN
    check_eq("ovf_flag", 32'(bus.overflow), 32'd1);
    check_eq("ovf_uflag", 32'(bus.underflow), 32'd0);
`endif

    // Drain plus two pops on an empty stack.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 8'd0);
      check_eq($sformatf("pop_dout_%0d", i), 32'(bus.data_out), 32'(pop_vals[i]));
      check_eq($sformatf("pop_empty_%0d", i), 32'(bus.empty), (i >= 7) ? 32'd1 : 32'd0);
      check_eq($sformatf("pop_full_%0d", i), 32'(bus.full), 32'd0);
    end
`ifdef LIFO_ERR_FLAGS_EN
    check_eq("unf_flag", 32'(bus.underflow), 32'd1);
`endif

    // Simultaneous push/pop replaces the top entry.
    cyc(1'b1, 1'b0, 8'd10);
    cyc(1'b1, 1'b0, 8'd20);
    cyc(1'b1, 1'b1, 8'd30);
    check_eq("swap_dout", 32'(bus.data_out), 32'd20);
    check_eq("swap_empty", 32'(bus.empty), 32'd0);
    cyc(1'b0, 1'b1, 8'd0);
    check_eq("swap_pop1", 32'(bus.data_out), 32'd30);
    check_eq("swap_empty1", 32'(bus.empty), 32'd0);
    cyc(1'b0, 1'b1, 8'd0);
    check_eq("swap_pop2", 32'(bus.data_out), 32'd10);
    check_eq("swap_empty2", 32'(bus.empty), 32'd1);

    // Push/pop on empty is a push only.
    cyc(1'b1, 1'b1, 8'd77);
    check_eq("we_re_empty_dout", 32'(bus.data_out), 32'd10);
    check_eq("we_re_empty_empty", 32'(bus.empty), 32'd0);
    cyc(1'b0, 1'b1, 8'd0);
    check_eq("we_re_empty_pop", 32'(bus.data_out), 32'd77);

    // Mid-operation reset with requests active discards everything.
    cyc(1'b1, 1'b0, 8'd1);
    cyc(1'b1, 1'b0, 8'd2);
    cyc(1'b1, 1'b0, 8'd3);
    rstn = 1'b0;
    cyc(1'b1, 1'b1, 8'd99);
    rstn = 1'b1;
    check_eq("mid_rst_empty", 32'(bus.empty), 32'd1);
    check_eq("mid_rst_full", 32'(bus.full), 32'd0);
    check_eq("mid_rst_dout", 32'(bus.data_out), 32'd0);
`ifdef LIFO_ERR_FLAGS_EN
    check_eq("mid_rst_ovf", 32'(bus.overflow), 32'd0);
    check_eq("mid_rst_unf", 32'(bus.underflow), 32'd0);
`endif
    cyc(1'b0, 1'b1, 8'd0);
    check_eq("post_rst_pop_dout", 32'(bus.data_out), 32'd0);
    check_eq("post_rst_pop_empty", 32'(bus.empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lifo.md
LIFO -- requirements
Module: lifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of storage entries; the value shall be a power of two and at least 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port we, input, 1 bit: push (write) request.
REQ-006 Port re, input, 1 bit: pop (read) request.
REQ-007 Port data_in, input, WIDTH bits: word to push.
REQ-008 Port empty, output, 1 bit: high when 0 entries are stored.
REQ-009 Port full, output, 1 bit: high when DEPTH entries are stored.
REQ-010 Port data_out, output, WIDTH bits: registered word from the last successful pop.
REQ-011 Port order shall be clk, rstn, we, re, data_in, empty, full, data_out, so that positional instantiation is supported.

Function
REQ-012 A stack pointer sp, $clog2(DEPTH)+1 bits wide, shall count stored entries in the range 0..DEPTH.
REQ-013 empty = (sp==0) and full = (sp==DEPTH), both combinational from sp.
REQ-014 Push (we=1, re=0, full=0): mem[sp] <= data_in and sp <= sp+1 on the clock edge.
REQ-015 Pop (re=1, we=0, empty=0): data_out <= mem[sp-1] and sp <= sp-1 on the clock edge, with 1-cycle latency from the re edge.
REQ-016 Push while full shall be ignored: memory, sp and data_out are unchanged.
REQ-017 Pop while empty shall be ignored: sp is unchanged and data_out holds its value.
REQ-018 With we=1, re=1 and empty=0, the block shall perform a simultaneous pop and push: data_out <= mem[sp-1], mem[sp-1] <= data_in, sp unchanged. This applies even when full=1.
REQ-019 With we=1, re=1 and empty=1, the block shall perform a push only.
REQ-020 data_out shall hold its value in every cycle without a successful pop.
REQ-021 Memory contents are not reset; an entry is only observable after it has been pushed.

Reset
REQ-022 When rstn=0 at a clock edge: sp <= 0 and data_out <= 0, so empty=1 and full=0 after that edge.
REQ-023 Reset shall dominate we and re, including when they are unknown.
REQ-024 Reset asserted mid-operation shall discard all stored entries.

Configuration
REQ-025 Macro LIFO_ERR_FLAGS_EN, when defined, shall add two output ports after data_out:
  - overflow (1 bit), set by a push while full;
  - underflow (1 bit), set by a pop while empty.
  Both flags are sticky and cleared only by reset.
REQ-026 When LIFO_ERR_FLAGS_EN is undefined, these ports and their logic shall be absent, and the port list shall be exactly the list in REQ-011.

Structure
REQ-027 Package lifo_pkg shall hold the default constants LIFO_WIDTH=8 and LIFO_DEPTH=8 and a function returning the pointer width.
REQ-028 Sub-module lifo_mem shall implement the storage: a DEPTH x WIDTH array with a synchronous write port and a combinational read port addressed by sp-1.
REQ-029 Pointer, flag and data_out control logic shall reside in lifo.

Verification
REQ-030 Reset, then idle -> empty=1, full=0, data_out=0.
REQ-031 Push 8 words 0..7 with values 3,1,4,1,5,2,6,5 -> full=1 after the 8th edge; 2 further pushes (7,0) are dropped, sp stays 8 and overflow=1 when enabled.
REQ-032 After REQ-031, pop 10 times -> data_out sequence 5,6,2,5,1,4,1,3 with each value one cycle after its re edge; empty=1 after the 8th pop; the last two pops leave data_out=3, underflow=1 when enabled.
REQ-033 Push 10,20, then we=re=1 with data_in=30 -> data_out=20, sp stays 2; the next pop returns 30, then 10.
REQ-034 Push 3 words, assert rstn=0 for one edge -> empty=1, data_out=0; a subsequent pop leaves data_out=0.
